// File: rtl/icmp_echo_responder.sv
// ICMP echo responder: buffers one complete Echo Request, validates its
// length and header, then replays it as an Echo Reply with the type cleared
// and the checksum adjusted incrementally. Drop and reply events are counted.
module icmp_echo_responder #(
    parameter int BUF_DEPTH = 1024,
    parameter int CNT_W     = 16,
    parameter int TX_GAP    = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [15:0]      i_icmp_len,
    input  logic [7:0]       i_icmp_data,
    input  logic             i_icmp_last,
    input  logic             i_icmp_valid,
    input  logic             i_tx_ready,
    output logic [15:0]      o_icmp_len,
    output logic [7:0]       o_icmp_data,
    output logic             o_icmp_last,
    output logic             o_icmp_valid,
    output logic [CNT_W-1:0] o_reply_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int          AW       = $clog2(BUF_DEPTH);
    localparam logic [16:0] DEPTH_L  = 17'(BUF_DEPTH);
    localparam logic [15:0] GAP_LAST = (TX_GAP > 0) ? 16'(TX_GAP - 1) : 16'd0;

    typedef enum logic [1:0] {R_IDLE, R_RECV, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP}  tx_state_t;

    // Message buffer and its registered read port
    logic [7:0]    mem [BUF_DEPTH];
    logic [7:0]    rdData_q;
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic          rdEn;
    logic [AW-1:0] rdAddr;

    // Receive side state
    rx_state_t   rxState_q, rxState_d;
    logic [15:0] rxCnt_q, rxCnt_d;
    logic [15:0] rxLen_q, rxLen_d;
    logic [15:0] rxCks_q, rxCks_d;
    logic        rxFlush_q, rxFlush_d;
    logic        dropEvt;
    logic        fullEvt;

    // Shared buffer ownership and the parameters of the stored message
    logic        bufFull_q;
    logic [15:0] txLen_q;
    logic [15:0] txCks_q;

    // Transmit side state
    tx_state_t   txState_q, txState_d;
    logic [15:0] fetch_q, fetch_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  outData_q, outData_d;
    logic        outValid_q, outValid_d;
    logic        outLast_q, outLast_d;
    logic [15:0] outLen_q, outLen_d;
    logic        replyEvt;
    logic        releaseEvt;

    logic [CNT_W-1:0] replyCnt_q;
    logic [CNT_W-1:0] dropCnt_q;

    logic [15:0] cntNext;
    logic [15:0] fetchNext;
    logic        lenShort;
    logic        lenLong;
    logic        xfer;
    logic [16:0] cksSum;
    logic [15:0] newCks;
    logic [7:0]  subByte;

    assign cntNext   = rxCnt_q + 16'd1;
    assign fetchNext = fetch_q + 16'd1;
    assign lenShort  = i_icmp_len < 16'd8;
    assign lenLong   = {1'b0, i_icmp_len} > DEPTH_L;
    assign xfer      = outValid_q && i_tx_ready;

    // Changing the type from 8 to 0 lowers the header sum by 0x0800, so the
    // one's-complement checksum rises by the same amount with end-around carry.
    assign cksSum = {1'b0, txCks_q} + 17'h00800;
    assign newCks = cksSum[15:0] + {15'd0, cksSum[16]};

    // Byte substitution for the reply header; everything else is replayed
    always_comb begin
        subByte = rdData_q;
        case (fetch_q)
            16'd0:   subByte = 8'h00;
            16'd1:   subByte = 8'h00;
            16'd2:   subByte = newCks[15:8];
            16'd3:   subByte = newCks[7:0];
            default: subByte = rdData_q;
        endcase
    end

    // Receive FSM: decide accept/drop per beat and generate buffer writes.
    // rxFlush marks the first message seen after reset, which may be the
    // tail of a message cut short by reset, so its drop is not counted.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxLen_d   = rxLen_q;
        rxCks_d   = rxCks_q;
        rxFlush_d = rxFlush_q;
        memWe     = 1'b0;
        memWaddr  = rxCnt_q[AW-1:0];
        dropEvt   = 1'b0;
        fullEvt   = 1'b0;
        if (i_icmp_valid) begin
            case (rxState_q)
                R_IDLE: begin
                    rxLen_d  = i_icmp_len;
                    rxCnt_d  = 16'd1;
                    memWaddr = '0;
                    if (bufFull_q || lenShort || lenLong ||
                        (i_icmp_data != 8'h08) || i_icmp_last) begin
                        if (i_icmp_last) begin
                            dropEvt   = !rxFlush_q;
                            rxFlush_d = 1'b0;
                        end else begin
                            rxState_d = R_DROP;
                        end
                    end else begin
                        memWe     = 1'b1;
                        rxFlush_d = 1'b0;
                        rxState_d = R_RECV;
                    end
                end
                R_RECV: begin
                    memWe   = 1'b1;
                    rxCnt_d = cntNext;
                    if (rxCnt_q == 16'd2) rxCks_d[15:8] = i_icmp_data;
                    if (rxCnt_q == 16'd3) rxCks_d[7:0]  = i_icmp_data;
                    if (i_icmp_last) begin
                        rxState_d = R_IDLE;
                        if ((cntNext == rxLen_q) &&
                            !((rxCnt_q == 16'd1) && (i_icmp_data != 8'h00)))
                            fullEvt = 1'b1;
                        else
                            dropEvt = 1'b1;
                    end else if (((rxCnt_q == 16'd1) && (i_icmp_data != 8'h00)) ||
                                 (cntNext == rxLen_q)) begin
                        rxState_d = R_DROP;
                    end
                end
                R_DROP: begin
                    if (i_icmp_last) begin
                        dropEvt   = !rxFlush_q;
                        rxFlush_d = 1'b0;
                        rxState_d = R_IDLE;
                    end
                end
                default: rxState_d = R_IDLE;
            endcase
        end
    end

    // Receive FSM registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rxState_q <= R_IDLE;
            rxCnt_q   <= '0;
            rxLen_q   <= '0;
            rxCks_q   <= '0;
            rxFlush_q <= 1'b1;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxLen_q   <= rxLen_d;
            rxCks_q   <= rxCks_d;
            rxFlush_q <= rxFlush_d;
        end
    end

    // Buffer ownership: set by a good message, released after the reply gap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bufFull_q <= 1'b0;
            txLen_q   <= '0;
            txCks_q   <= '0;
        end else begin
            if (fullEvt) begin
                bufFull_q <= 1'b1;
                txLen_q   <= rxLen_q;
                txCks_q   <= rxCks_q;
            end else if (releaseEvt) begin
                bufFull_q <= 1'b0;
            end
        end
    end

    // Buffer storage; no reset so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (memWe) mem[memWaddr] <= i_icmp_data;
        if (rdEn)  rdData_q      <= mem[rdAddr];
    end

    // Transmit FSM: rdData always holds the byte at index fetch, so a new
    // output byte can be loaded on every transfer without a bubble.
    always_comb begin
        txState_d  = txState_q;
        fetch_d    = fetch_q;
        gap_d      = gap_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outLen_d   = outLen_q;
        rdEn       = 1'b0;
        rdAddr     = fetch_q[AW-1:0];
        replyEvt   = 1'b0;
        releaseEvt = 1'b0;
        case (txState_q)
            T_IDLE: begin
                if (bufFull_q) begin
                    rdEn      = 1'b1;
                    rdAddr    = '0;
                    fetch_d   = '0;
                    outLen_d  = txLen_q;
                    txState_d = T_SEND;
                end
            end
            T_SEND: begin
                if (xfer && outLast_q) begin
                    outValid_d = 1'b0;
                    outLast_d  = 1'b0;
                    outData_d  = '0;
                    outLen_d   = '0;
                    replyEvt   = 1'b1;
                    gap_d      = '0;
                    if (TX_GAP == 0) begin
                        releaseEvt = 1'b1;
                        txState_d  = T_IDLE;
                    end else begin
                        txState_d  = T_GAP;
                    end
                end else if ((!outValid_q || xfer) && (fetch_q < txLen_q)) begin
                    rdEn       = 1'b1;
                    rdAddr     = fetchNext[AW-1:0];
                    fetch_d    = fetchNext;
                    outValid_d = 1'b1;
                    outData_d  = subByte;
                    outLast_d  = (fetch_q == (txLen_q - 16'd1));
                end
            end
            T_GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == GAP_LAST) begin
                    releaseEvt = 1'b1;
                    txState_d  = T_IDLE;
                end
            end
            default: txState_d = T_IDLE;
        endcase
    end

    // Transmit FSM and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            txState_q  <= T_IDLE;
            fetch_q    <= '0;
            gap_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outLen_q   <= '0;
        end else begin
            txState_q  <= txState_d;
            fetch_q    <= fetch_d;
            gap_q      <= gap_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outLen_q   <= outLen_d;
        end
    end

    // Statistics counters, free-running with natural wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            replyCnt_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            if (replyEvt) replyCnt_q <= replyCnt_q + 1'b1;
            if (dropEvt)  dropCnt_q  <= dropCnt_q + 1'b1;
        end
    end

    assign o_icmp_len   = outLen_q;
    assign o_icmp_data  = outData_q;
    assign o_icmp_last  = outLast_q;
    assign o_icmp_valid = outValid_q;
    assign o_reply_cnt  = replyCnt_q;
    assign o_drop_cnt   = dropCnt_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Scoreboard bench for icmp_echo_responder: requests are modelled as whole
// messages, expected reply beats are queued, and a monitor checks every
// transferred beat plus output stability while the sink stalls.
module tb_icmp_echo_responder;

   localparam int BUF_DEPTH = 1024;
   localparam int CNT_W     = 16;
   localparam int TX_GAP    = 12;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [15:0]      i_icmp_len;
   logic [7:0]       i_icmp_data;
   logic             i_icmp_last;
   logic             i_icmp_valid;
   logic             i_tx_ready;
   logic [15:0]      o_icmp_len;
   logic [7:0]       o_icmp_data;
   logic             o_icmp_last;
   logic             o_icmp_valid;
   logic [CNT_W-1:0] o_reply_cnt;
   logic [CNT_W-1:0] o_drop_cnt;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [15:0] len;
   } beat_t;

   beat_t      expQ[$];
   logic [7:0] msg[$];
   int compared   = 0;
   int mismatched = 0;
   int expReplies = 0;
   int expDrops   = 0;
   int readyMode  = 0;
   int readyPhase = 0;

   icmp_echo_responder #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .TX_GAP(TX_GAP)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_icmp_len(i_icmp_len), .i_icmp_data(i_icmp_data),
      .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid),
      .i_tx_ready(i_tx_ready),
      .o_icmp_len(o_icmp_len), .o_icmp_data(o_icmp_data),
      .o_icmp_last(o_icmp_last), .o_icmp_valid(o_icmp_valid),
      .o_reply_cnt(o_reply_cnt), .o_drop_cnt(o_drop_cnt)
   );

   // Free-running clock
   always #5 i_clk = ~i_clk;

   // Single comparison point; every check goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Build a message of n bytes with the given header fields
   task automatic buildMsg(input int n, input logic [7:0] typ, input logic [7:0] code,
                           input logic [15:0] cks, input logic [15:0] id,
                           input logic [15:0] seq, input bit incPayload);
      msg.delete();
      for (int i = 0; i < n; i++) begin
         case (i)
            0: msg.push_back(typ);
            1: msg.push_back(code);
            2: msg.push_back(cks[15:8]);
            3: msg.push_back(cks[7:0]);
            4: msg.push_back(id[15:8]);
            5: msg.push_back(id[7:0]);
            6: msg.push_back(seq[15:8]);
            7: msg.push_back(seq[7:0]);
            default: msg.push_back(incPayload ? 8'(i - 8) : 8'($urandom_range(0, 255)));
         endcase
      end
   endtask

   // Drive msg[from..to]; the declared length goes out only with byte 0
   task automatic applyRange(input int from, input int to, input int declLen, input int gapPct);
      for (int i = from; i <= to; i++) begin
         if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
            i_icmp_valid = 1'b0;
            @(posedge i_clk); #1;
         end
         i_icmp_valid = 1'b1;
         i_icmp_data  = msg[i];
         i_icmp_last  = (i == msg.size() - 1);
         i_icmp_len   = (i == 0) ? 16'(declLen) : 16'd0;
         @(posedge i_clk); #1;
      end
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
      i_icmp_data  = 8'h00;
      i_icmp_len   = 16'd0;
   endtask

   // Reference model: a request is answered only if the buffer was free,
   // its length is legal and fully delivered, and it is an echo request
   function automatic bit modelAccepts(input int declLen, input bit busy);
      if (busy) return 1'b0;
      if (declLen < 8 || declLen > BUF_DEPTH) return 1'b0;
      if (msg.size() != declLen) return 1'b0;
      if (msg[0] != 8'h08 || msg[1] != 8'h00) return 1'b0;
      return 1'b1;
   endfunction

   // Reference reply: type/code zeroed, checksum + 0x0800 with end-around carry
   function automatic void pushReply(input int declLen);
      int cks;
      int s;
      int nc;
      beat_t b;
      cks = {msg[2], msg[3]};
      s   = cks + 32'h0800;
      nc  = (s & 32'hFFFF) + (s >> 16);
      for (int i = 0; i < declLen; i++) begin
         if (i < 2)       b.data = 8'h00;
         else if (i == 2) b.data = nc[15:8];
         else if (i == 3) b.data = nc[7:0];
         else             b.data = msg[i];
         b.last = (i == declLen - 1);
         b.len  = 16'(declLen);
         expQ.push_back(b);
      end
   endfunction

   // Send the current message and record what the model predicts
   task automatic applyStimulus(input int declLen, input bit busy, input int gapPct);
      applyRange(0, msg.size() - 1, declLen, gapPct);
      if (modelAccepts(declLen, busy)) begin
         pushReply(declLen);
         expReplies++;
      end else begin
         expDrops++;
      end
   endtask

   // Wait until every expected beat has been seen, bounded
   task automatic waitDrained();
      int guard = 0;
      while ((expQ.size() != 0 || o_icmp_valid) && guard < 20000) begin
         @(negedge i_clk);
         guard++;
      end
      if (guard >= 20000) begin
         checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   task automatic waitIdle();
      waitDrained();
      repeat (TX_GAP + 4) @(posedge i_clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_reply_cnt"}, 32'(o_reply_cnt), 32'(expReplies[CNT_W-1:0]));
      checkOutput({tag, "_drop_cnt"},  32'(o_drop_cnt),  32'(expDrops[CNT_W-1:0]));
   endtask

   // Downstream ready: always on, 1-0-0-1 pattern, or random
   initial begin
      i_tx_ready = 1'b1;
      forever begin
         @(posedge i_clk); #1;
         case (readyMode)
            0: i_tx_ready = 1'b1;
            1: begin
               i_tx_ready = (readyPhase == 0 || readyPhase == 3);
               readyPhase = (readyPhase + 1) % 4;
            end
            default: i_tx_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pop and compare on each transfer, check stability on stalls
   initial begin : monitor
      beat_t e;
      bit stalled;
      logic [10:0] heldVec;
      stalled = 1'b0;
      heldVec = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               checkOutput("hold_stable", 32'({o_icmp_valid, o_icmp_last, o_icmp_data}), 32'(heldVec));
            if (o_icmp_valid && i_tx_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", 32'(o_icmp_valid), 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("reply_beat", 32'({o_icmp_len, o_icmp_last, o_icmp_data}),
                              32'({e.len, e.last, e.data}));
               end
            end
            stalled = o_icmp_valid && !i_tx_ready;
            heldVec = {o_icmp_valid, o_icmp_last, o_icmp_data};
         end
      end
   end

   // Absolute time bound so the run always ends
   initial begin
      #3ms;
      checkOutput("watchdog", 32'(expQ.size()), 32'hFFFF_FFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      int run;
      int declLen;
      int n;
      int r;
      logic [7:0] typ;
      logic [7:0] code;

      i_rst = 1'b1;
      i_icmp_len = '0; i_icmp_data = '0; i_icmp_last = 1'b0; i_icmp_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("reset_valid", 32'(o_icmp_valid), 32'd0);
      checkOutput("reset_outputs", 32'({o_icmp_len, o_icmp_data, o_icmp_last}), 32'd0);
      checkCounters("reset");
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;

      // Scenario 1: basic 40-byte request, latency and contiguity
      $display("[TB] scenario 1: basic echo");
      buildMsg(40, 8'h08, 8'h00, 16'h1234, 16'h0001, 16'h0007, 1'b1);
      applyStimulus(40, 1'b0, 0);
      @(negedge i_clk);
      @(negedge i_clk);
      checkOutput("latency_not_early", 32'(o_icmp_valid), 32'd0);
      @(negedge i_clk);
      checkOutput("latency_rise", 32'(o_icmp_valid), 32'd1);
      run = 1;
      repeat (39) begin
         @(negedge i_clk);
         if (o_icmp_valid) run++;
      end
      checkOutput("contiguous_beats", 32'(run), 32'd40);
      @(negedge i_clk);
      checkOutput("valid_after_last", 32'(o_icmp_valid), 32'd0);
      waitIdle();
      checkCounters("s1");

      // Scenario 2: checksum carry cases
      $display("[TB] scenario 2: checksum wrap");
      buildMsg(24, 8'h08, 8'h00, 16'hF800, 16'h1111, 16'h0002, 1'b0);
      applyStimulus(24, 1'b0, 0);
      waitIdle();
      buildMsg(24, 8'h08, 8'h00, 16'hF7FF, 16'h2222, 16'h0003, 1'b0);
      applyStimulus(24, 1'b0, 0);
      waitIdle();
      checkCounters("s2");

      // Scenario 3: backpressure pattern
      $display("[TB] scenario 3: ready toggling");
      readyMode = 1;
      buildMsg(40, 8'h08, 8'h00, 16'h1234, 16'h0001, 16'h0007, 1'b1);
      applyStimulus(40, 1'b0, 0);
      waitIdle();
      readyMode = 0;
      checkCounters("s3");

      // Scenario 4: bad type, short delivery, oversize, then exact-depth
      $display("[TB] scenario 4: drops and max length");
      buildMsg(20, 8'h00, 8'h00, 16'hABCD, 16'h0001, 16'h0001, 1'b1);
      applyStimulus(20, 1'b0, 0);
      buildMsg(19, 8'h08, 8'h00, 16'hABCD, 16'h0001, 16'h0002, 1'b1);
      applyStimulus(20, 1'b0, 0);
      buildMsg(BUF_DEPTH + 1, 8'h08, 8'h00, 16'hABCD, 16'h0001, 16'h0003, 1'b0);
      applyStimulus(BUF_DEPTH + 1, 1'b0, 0);
      waitIdle();
      checkCounters("s4_drops");
      buildMsg(BUF_DEPTH, 8'h08, 8'h00, 16'h0F0F, 16'h0101, 16'h0202, 1'b0);
      applyStimulus(BUF_DEPTH, 1'b0, 0);
      waitIdle();
      checkCounters("s4_max");

      // Scenario 5: request during the post-reply gap is refused
      $display("[TB] scenario 5: busy drop");
      buildMsg(32, 8'h08, 8'h00, 16'h4321, 16'h0005, 16'h0001, 1'b0);
      applyStimulus(32, 1'b0, 0);
      waitDrained();
      repeat (3) @(posedge i_clk);
      #1;
      buildMsg(16, 8'h08, 8'h00, 16'h5555, 16'h0005, 16'h0002, 1'b0);
      applyStimulus(16, 1'b1, 0);
      waitIdle();
      buildMsg(16, 8'h08, 8'h00, 16'h6666, 16'h0005, 16'h0003, 1'b0);
      applyStimulus(16, 1'b0, 0);
      waitIdle();
      checkCounters("s5");

      // Randomized traffic with random backpressure and input gaps
      $display("[TB] random traffic");
      readyMode = 2;
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         declLen = (r == 0) ? $urandom_range(0, 7) : $urandom_range(8, 96);
         r = $urandom_range(0, 9);
         if (r == 0)      n = (declLen > 1) ? declLen - 1 : 1;
         else if (r == 1) n = declLen + 1;
         else             n = (declLen > 0) ? declLen : 1;
         typ  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(9, 255)) : 8'h08;
         code = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         buildMsg(n, typ, code, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 1'b0);
         applyStimulus(declLen, 1'b0, ($urandom_range(0, 1) == 1) ? 20 : 0);
         waitIdle();
      end
      readyMode = 0;
      checkCounters("random");

      // Scenario 6: reset during a reply and during an incoming message
      $display("[TB] scenario 6: reset mid-reply");
      buildMsg(40, 8'h08, 8'h00, 16'h1234, 16'h0001, 16'h0007, 1'b1);
      applyStimulus(40, 1'b0, 0);
      buildMsg(40, 8'h08, 8'h00, 16'h7777, 16'h0009, 16'h0009, 1'b0);
      applyRange(0, 10, 40, 0);
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("rst_valid", 32'(o_icmp_valid), 32'd0);
      checkOutput("rst_data_last_len", 32'({o_icmp_len, o_icmp_data, o_icmp_last}), 32'd0);
      checkOutput("rst_reply_cnt", 32'(o_reply_cnt), 32'd0);
      checkOutput("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
      expQ.delete();
      expReplies = 0;
      expDrops   = 0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      applyRange(11, 39, 40, 0);
      repeat (3) @(posedge i_clk);
      #1;
      buildMsg(40, 8'h08, 8'h00, 16'hF800, 16'h0010, 16'h0020, 1'b1);
      applyStimulus(40, 1'b0, 0);
      waitIdle();
      checkCounters("s6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
